// File: rtl/mips_pkg.sv
// Shared decode constants, scoreboard slot type and interlock FSM encoding
// for the 16-bit MIPS-style pipeline.
package mips_pkg;

    localparam logic [3:0] OP_RFMT = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_SLTI = 4'd3;
    localparam logic [3:0] OP_LW   = 4'd4;
    localparam logic [3:0] OP_SW   = 4'd5;
    localparam logic [3:0] OP_BEQ  = 4'd6;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RS_MSB = 11;
    localparam int RS_LSB = 9;
    localparam int RT_MSB = 8;
    localparam int RT_LSB = 6;
    localparam int RD_MSB = 5;
    localparam int RD_LSB = 3;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_LU_STALL = 2'd1,
        S_FLUSH    = 2'd2
    } il_state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] dest;
        logic       is_load;
    } sb_slot_t;

endpackage

// File: rtl/instr_reg_decode.sv
// Register-usage decoder: destination, up to two sources and load flag.
// Register 0 never appears as a valid source or destination.
module instr_reg_decode
    import mips_pkg::*;
(
    input  logic [15:0] instr,
    output logic [2:0]  dest,
    output logic        dest_valid,
    output logic [2:0]  src1,
    output logic        src1_valid,
    output logic [2:0]  src2,
    output logic        src2_valid,
    output logic        is_load
);

    logic [3:0] op;
    logic [2:0] rs, rt, rd;
    logic       dv, s1v, s2v;
    logic       unused_funct;

    assign op = instr[OP_MSB:OP_LSB];
    assign rs = instr[RS_MSB:RS_LSB];
    assign rt = instr[RT_MSB:RT_LSB];
    assign rd = instr[RD_MSB:RD_LSB];
    assign unused_funct = ^instr[2:0];

    always_comb begin
        dest    = 3'd0;
        dv      = 1'b0;
        src1    = 3'd0;
        s1v     = 1'b0;
        src2    = 3'd0;
        s2v     = 1'b0;
        is_load = 1'b0;
        case (op)
            OP_RFMT: begin
                dest = rd; dv = 1'b1;
                src1 = rs; s1v = 1'b1;
                src2 = rt; s2v = 1'b1;
            end
            OP_ADDI, OP_SLTI: begin
                dest = rs; dv = 1'b1;
                src1 = rt; s1v = 1'b1;
            end
            OP_LW: begin
                dest = rt; dv = 1'b1;
                src1 = rs; s1v = 1'b1;
                is_load = 1'b1;
            end
            OP_SW, OP_BEQ: begin
                src1 = rs; s1v = 1'b1;
                src2 = rt; s2v = 1'b1;
            end
            default: ;
        endcase
        dest_valid = dv  && (dest != 3'd0);
        src1_valid = s1v && (src1 != 3'd0);
        src2_valid = s2v && (src2 != 3'd0);
    end

endmodule

// File: rtl/pipeline_interlock.sv
// Load-use stall / branch flush interlock with a two-slot (EX, MEM) scoreboard.
// Define INTERLOCK_STALL_CNT_EN to build the saturating stall-cycle counter.
module pipeline_interlock
    import mips_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] id_instr,
    input  logic        id_valid,
    input  logic        branch_taken,
    output logic        stall,
    output logic        bubble,
    output logic        flush,
    output logic [15:0] stall_count
);

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    logic [2:0] d_dest, d_src1, d_src2;
    logic       d_dest_valid, d_src1_valid, d_src2_valid, d_is_load;

    instr_reg_decode u_dec (
        .instr      (id_instr),
        .dest       (d_dest),
        .dest_valid (d_dest_valid),
        .src1       (d_src1),
        .src1_valid (d_src1_valid),
        .src2       (d_src2),
        .src2_valid (d_src2_valid),
        .is_load    (d_is_load)
    );

    il_state_e state, state_nxt;
    logic [1:0] fcnt, fcnt_nxt;
    sb_slot_t   ex_q, mem_q, ex_nxt;
    logic       hazard;
    logic       unused_mem;

    // MEM is tracked for the forwarding unit; nothing here consumes it.
    assign unused_mem = ^mem_q;

    assign hazard = id_valid && ex_q.valid && ex_q.is_load && (ex_q.dest != 3'd0) &&
                    ((d_src1_valid && d_src1 == ex_q.dest) ||
                     (d_src2_valid && d_src2 == ex_q.dest));

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        stall     = 1'b0;
        bubble    = 1'b0;
        flush     = 1'b0;
        if (rst) begin
            state_nxt = S_RUN;
            fcnt_nxt  = 2'd0;
        end else if (branch_taken) begin
            flush     = 1'b1;
            bubble    = 1'b1;
            fcnt_nxt  = FLUSH_LOAD;
            state_nxt = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
        end else begin
            case (state)
                S_RUN: begin
                    if (hazard) begin
                        stall     = 1'b1;
                        bubble    = 1'b1;
                        state_nxt = S_LU_STALL;
                    end
                end
                S_LU_STALL: state_nxt = S_RUN;
                S_FLUSH: begin
                    flush    = 1'b1;
                    bubble   = 1'b1;
                    fcnt_nxt = fcnt - 2'd1;
                    if (fcnt <= 2'd1) state_nxt = S_RUN;
                end
                default: state_nxt = S_RUN;
            endcase
        end
    end

    always_comb begin
        ex_nxt = '0;
        if (!(bubble || flush || !id_valid)) begin
            ex_nxt.valid   = 1'b1;
            ex_nxt.dest    = d_dest_valid ? d_dest : 3'd0;
            ex_nxt.is_load = d_is_load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
            fcnt  <= 2'd0;
            ex_q  <= '0;
            mem_q <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
            mem_q <= ex_q;
            ex_q  <= ex_nxt;
        end
    end

`ifdef INTERLOCK_STALL_CNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= 16'd0;
        else if (stall && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign stall_count = stall_cnt;
`else
    assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_interlock.sv
// Directed and random checks of pipeline_interlock against a register-set
// reference model of load-use stalls and branch flushes.
module tb_pipeline_interlock;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] id_instr = 16'd0;
    logic        id_valid = 1'b0;
    logic        branch_taken = 1'b0;
    logic        stall, bubble, flush;
    logic [15:0] stall_count;

    int n_chk  = 0;
    int n_fail = 0;

    // model: register loaded by the instruction now in EX (0 = none),
    // remaining flush cycles, whether last cycle was a load-use stall
    int m_ex_dest = 0;
    int m_frem    = 0;
    bit m_after   = 1'b0;
    int m_cnt     = 0;

    pipeline_interlock #(.FLUSH_CYCLES(FC)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_instr     (id_instr),
        .id_valid     (id_valid),
        .branch_taken (branch_taken),
        .stall        (stall),
        .bubble       (bubble),
        .flush        (flush),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input int op, input int rs, input int rt, input int rd);
        logic [15:0] v;
        v = {op[3:0], rs[2:0], rt[2:0], rd[2:0], 3'b000};
        return v;
    endfunction

    // bitmask of registers read by the instruction, r0 excluded
    function automatic int src_mask(input logic [15:0] i);
        int op, rs, rt, m;
        op = int'(i[15:12]); rs = int'(i[11:9]); rt = int'(i[8:6]);
        case (op)
            0, 5, 6: m = (1 << rs) | (1 << rt);
            1, 3:    m = 1 << rt;
            4:       m = 1 << rs;
            default: m = 0;
        endcase
        return m & ~1;
    endfunction

    function automatic int load_dest(input logic [15:0] i);
        return (i[15:12] == 4'd4) ? int'(i[8:6]) : 0;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [15:0] ins, input bit v, input bit br, input bit r);
        bit es, eb, ef;
        @(negedge clk);
        id_instr = ins; id_valid = v; branch_taken = br; rst = r;
        #1;
`ifdef INTERLOCK_STALL_CNT_EN
        chk("stall_count", stall_count, 16'(m_cnt));
`else
        chk("stall_count", stall_count, 16'd0);
`endif
        es = 1'b0; eb = 1'b0; ef = 1'b0;
        if (r) begin
            m_ex_dest = 0; m_frem = 0; m_after = 1'b0;
        end else if (br) begin
            ef = 1'b1; eb = 1'b1;
            m_frem = FC - 1; m_after = 1'b0; m_ex_dest = 0;
        end else if (m_frem > 0) begin
            ef = 1'b1; eb = 1'b1;
            m_frem--; m_ex_dest = 0;
        end else if (!m_after && v && m_ex_dest != 0 && ((src_mask(ins) >> m_ex_dest) & 1) == 1) begin
            es = 1'b1; eb = 1'b1;
            m_after = 1'b1; m_ex_dest = 0;
        end else begin
            m_after = 1'b0;
            m_ex_dest = v ? load_dest(ins) : 0;
        end
        chk("stall", 16'(stall), 16'(es));
        chk("bubble", 16'(bubble), 16'(eb));
        chk("flush", 16'(flush), 16'(ef));
        if (r) m_cnt = 0;
        else if (es && m_cnt < 65535) m_cnt++;
    endtask

    logic [15:0] lw_r2, add_r2;

    initial begin
        lw_r2  = mk(4, 1, 2, 0);
        add_r2 = mk(0, 2, 4, 3);

        // reset dominates every input
        step(add_r2, 1, 1, 1);
        chk("rst_flush", 16'(flush), 16'd0);
        step(16'd0, 0, 0, 1);

        // lw r2,(r1); add r3,r2,r4 -> one stall, add leaves ID next cycle
        step(lw_r2, 1, 0, 0);
        step(add_r2, 1, 0, 0);
        chk("lu_stall", 16'(stall), 16'd1);
        chk("lu_bubble", 16'(bubble), 16'd1);
        step(add_r2, 1, 0, 0);
        chk("lu_release", 16'({stall, bubble}), 16'd0);
        step(16'd0, 0, 0, 0);

        // lw into r0 never hazards
        step(mk(4, 1, 0, 0), 1, 0, 0);
        step(mk(0, 0, 0, 3), 1, 0, 0);
        chk("r0_nostall", 16'(stall), 16'd0);

        // ALU result is forwarded, no stall
        step(mk(0, 1, 1, 2), 1, 0, 0);
        step(mk(0, 2, 2, 3), 1, 0, 0);
        chk("alu_nostall", 16'(stall), 16'd0);

        // branch: flush for exactly FC cycles
        step(16'd0, 0, 1, 0);
        chk("br_flush0", 16'(flush), 16'd1);
        step(16'd0, 0, 0, 0);
        chk("br_flush1", 16'(flush), 16'd1);
        step(16'd0, 0, 0, 0);
        chk("br_done", 16'({flush, bubble}), 16'd0);

        // hazard coincident with branch: flush wins; reset mid-flush
        step(lw_r2, 1, 0, 0);
        step(add_r2, 1, 1, 0);
        chk("br_hz_flush", 16'(flush), 16'd1);
        chk("br_hz_stall", 16'(stall), 16'd0);
        step(add_r2, 1, 0, 1);
        step(add_r2, 1, 0, 0);
        chk("post_rst", 16'({stall, bubble, flush}), 16'd0);

`ifdef INTERLOCK_STALL_CNT_EN
        step(16'd0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            step(lw_r2, 1, 0, 0);
            step(add_r2, 1, 0, 0);
            step(add_r2, 1, 0, 0);
        end
        step(16'd0, 0, 0, 0);
        chk("cnt3", stall_count, 16'd3);
        @(negedge clk);
        dut.stall_cnt = 16'hFFFF;
        m_cnt = 65535;
        step(lw_r2, 1, 0, 0);
        step(add_r2, 1, 0, 0);
        step(16'd0, 0, 0, 0);
        chk("cnt_sat", stall_count, 16'hFFFF);
`endif

        for (int n = 0; n < 400; n++) begin
            int op;
            op = ($urandom_range(0, 2) == 0) ? 4 : int'($urandom_range(0, 7));
            step(mk(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3))),
                 $urandom_range(0, 7) != 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 49) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
